axi_ddr3_tester: RTL and testbench

AXI4 burst initiator that drives the memory controller's AXI write and read ports as a built-in memory test. It writes a deterministic pattern over a configurable region in fixed-length INCR bursts. It then reads the region back and compares every beat, reporting pass/fail and an error count. It sits upstream of the memory controller, on-chip for bring-up and in testbenches, and is the master end of the controller's AXI slave ports.

---
 rtl/axi_ddr3_tester.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi_ddr3_tester.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ddr3_tester.sv
// axi_ddr3_tester: AXI4 burst initiator used as a built-in memory test.
// Writes a seeded pattern over NUM_BURSTS INCR bursts of BURST_LEN beats,
// reads the region back, and counts every mismatching beat or bad response.
// Ports:
//   clock, arst_n               clock and asynchronous active-low reset
//   start_i, seed_i             start a pass; seed sampled on acceptance
//   busy_o, done_o, pass_o      status (done/pass sticky until next start)
//   err_count_o                 saturating error count
//   axi_aw*/axi_w*/axi_b*       AXI write channels (master side)
//   axi_ar*/axi_r*              AXI read channels (master side)
module axi_ddr3_tester #(
   parameter int unsigned                ADDRS        = 29,
   parameter int unsigned                DATA_BITS    = 32,
   parameter int unsigned                STRB_BITS    = 4,
   parameter int unsigned                AXI_ID_WIDTH = 4,
   parameter logic [AXI_ID_WIDTH-1:0]    ID_VALUE     = 4'h5,
   parameter int unsigned                BURST_LEN    = 16,
   parameter int unsigned                NUM_BURSTS   = 64,
   parameter logic [ADDRS-1:0]           BASE_ADDR    = '0
) (
   input  logic                    clock,
   input  logic                    arst_n,
   input  logic                    start_i,
   input  logic [31:0]             seed_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic [15:0]             err_count_o,
   // AW channel
   output logic                    axi_awvalid_o,
   input  logic                    axi_awready_i,
   output logic [ADDRS-1:0]        axi_awaddr_o,
   output logic [AXI_ID_WIDTH-1:0] axi_awid_o,
   output logic [7:0]              axi_awlen_o,
   output logic [1:0]              axi_awburst_o,
   // W channel
   output logic                    axi_wvalid_o,
   input  logic                    axi_wready_i,
   output logic                    axi_wlast_o,
   output logic [STRB_BITS-1:0]    axi_wstrb_o,
   output logic [DATA_BITS-1:0]    axi_wdata_o,
   // B channel
   input  logic                    axi_bvalid_i,
   output logic                    axi_bready_o,
   input  logic [1:0]              axi_bresp_i,
   input  logic [AXI_ID_WIDTH-1:0] axi_bid_i,
   // AR channel
   output logic                    axi_arvalid_o,
   input  logic                    axi_arready_i,
   output logic [ADDRS-1:0]        axi_araddr_o,
   output logic [AXI_ID_WIDTH-1:0] axi_arid_o,
   output logic [7:0]              axi_arlen_o,
   output logic [1:0]              axi_arburst_o,
   // R channel
   input  logic                    axi_rvalid_i,
   output logic                    axi_rready_o,
   input  logic                    axi_rlast_i,
   input  logic [1:0]              axi_rresp_i,
   input  logic [AXI_ID_WIDTH-1:0] axi_rid_i,
   input  logic [DATA_BITS-1:0]    axi_rdata_i
);

   localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int unsigned K_W     = 32;

   localparam logic [ADDRS-1:0]   ADDR_STEP  = ADDRS'(BURST_LEN * STRB_BITS);
   localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
   localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   // Pattern for global beat k: upper half is the complement of the lower half
   function automatic logic [DATA_BITS-1:0] pattern(input logic [K_W-1:0] k,
                                                    input logic [DATA_BITS-1:0] seed);
      return {~k[15:0], k[15:0]} ^ seed;
   endfunction

   // Add up to 4 errors, clamping at all-ones
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
      logic [16:0] s;
      s = {1'b0, a} + 17'(b);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   state_t                 state_q,   state_d;
   logic [DATA_BITS-1:0]   seed_q,    seed_d;
   logic [ADDRS-1:0]       addr_q,    addr_d;
   logic [BEAT_W-1:0]      beat_q,    beat_d;
   logic [BURST_W-1:0]     burst_q,   burst_d;
   logic [K_W-1:0]         k_q,       k_d;
   logic [15:0]            err_q,     err_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;
   logic                   pass_q,    pass_d;
   logic                   awvalid_q, awvalid_d;
   logic                   wvalid_q,  wvalid_d;
   logic                   wlast_q,   wlast_d;
   logic [DATA_BITS-1:0]   wdata_q,   wdata_d;
   logic                   bready_q,  bready_d;
   logic                   arvalid_q, arvalid_d;
   logic                   rready_q,  rready_d;

   logic [DATA_BITS-1:0]   rd_exp;
   logic [2:0]             rd_errs;
   logic [15:0]            err_next;

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      seed_d    = seed_q;
      addr_d    = addr_q;
      beat_d    = beat_q;
      burst_d   = burst_q;
      k_d       = k_q;
      err_d     = err_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      wlast_d   = wlast_q;
      wdata_d   = wdata_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;

      // Each failing condition on a read beat costs one error
      rd_exp   = pattern(k_q, seed_q);
      rd_errs  = 3'(axi_rdata_i != rd_exp)
               + 3'(axi_rresp_i != 2'b00)
               + 3'(axi_rid_i != ID_VALUE)
               + 3'(axi_rlast_i != (beat_q == LAST_BEAT));
      err_next = sat_add(err_q, rd_errs);

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               seed_d    = seed_i;
               err_d     = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               addr_d    = BASE_ADDR;
               k_d       = '0;
               beat_d    = '0;
               burst_d   = '0;
               awvalid_d = 1'b1;
               state_d   = WR_ADDR;
            end
         end
         WR_ADDR: begin
            if (axi_awready_i) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               wdata_d   = pattern(k_q, seed_q);
               wlast_d   = (LAST_BEAT == '0);
               state_d   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (axi_wready_i) begin
               k_d = k_q + K_W'(1);
               if (beat_q == LAST_BEAT) begin
                  beat_d   = '0;
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  bready_d = 1'b1;
                  state_d  = WR_RESP;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  wdata_d = pattern(k_q + K_W'(1), seed_q);
                  wlast_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
               end
            end
         end
         WR_RESP: begin
            if (axi_bvalid_i) begin
               bready_d = 1'b0;
               if ((axi_bresp_i != 2'b00) || (axi_bid_i != ID_VALUE))
                  err_d = sat_add(err_q, 3'd1);
               if (burst_q == LAST_BURST) begin
                  // Write phase complete: rewind for the read-back
                  burst_d   = '0;
                  k_d       = '0;
                  addr_d    = BASE_ADDR;
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end else begin
                  burst_d   = burst_q + BURST_W'(1);
                  addr_d    = addr_q + ADDR_STEP;
                  awvalid_d = 1'b1;
                  state_d   = WR_ADDR;
               end
            end
         end
         RD_ADDR: begin
            if (axi_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (axi_rvalid_i) begin
               err_d = err_next;
               k_d   = k_q + K_W'(1);
               // Burst ends on the beat count alone; rlast only feeds the error check
               if (beat_q == LAST_BEAT) begin
                  beat_d   = '0;
                  rready_d = 1'b0;
                  if (burst_q == LAST_BURST) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (err_next == '0);
                     state_d = DONE;
                  end else begin
                     burst_d   = burst_q + BURST_W'(1);
                     addr_d    = addr_q + ADDR_STEP;
                     arvalid_d = 1'b1;
                     state_d   = RD_ADDR;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         seed_q    <= '0;
         addr_q    <= '0;
         beat_q    <= '0;
         burst_q   <= '0;
         k_q       <= '0;
         err_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wlast_q   <= 1'b0;
         wdata_q   <= '0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         seed_q    <= seed_d;
         addr_q    <= addr_d;
         beat_q    <= beat_d;
         burst_q   <= burst_d;
         k_q       <= k_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         wlast_q   <= wlast_d;
         wdata_q   <= wdata_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign pass_o        = pass_q;
   assign err_count_o   = err_q;

   assign axi_awvalid_o = awvalid_q;
   assign axi_awaddr_o  = addr_q;
   assign axi_awid_o    = ID_VALUE;
   assign axi_awlen_o   = 8'(BURST_LEN - 1);
   assign axi_awburst_o = 2'b01;

   assign axi_wvalid_o  = wvalid_q;
   assign axi_wlast_o   = wlast_q;
   assign axi_wstrb_o   = '1;
   assign axi_wdata_o   = wdata_q;

   assign axi_bready_o  = bready_q;

   assign axi_arvalid_o = arvalid_q;
   assign axi_araddr_o  = addr_q;
   assign axi_arid_o    = ID_VALUE;
   assign axi_arlen_o   = 8'(BURST_LEN - 1);
   assign axi_arburst_o = 2'b01;

   assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi_ddr3_tester.sv
// Bench for axi_ddr3_tester: behavioural AXI slave with memory, optional
// random stalls and injected faults; table-driven passes plus reset/start
// corner sequences.
module tb_axi_ddr3_tester;

   localparam int unsigned BL = 16;
   localparam int unsigned NB = 4;

   logic        clock = 1'b0;
   logic        arst_n;
   logic        start_i;
   logic [31:0] seed_i;
   logic        busy_o, done_o, pass_o;
   logic [15:0] err_count_o;
   logic        axi_awvalid_o, axi_awready_i;
   logic [28:0] axi_awaddr_o;
   logic [3:0]  axi_awid_o;
   logic [7:0]  axi_awlen_o;
   logic [1:0]  axi_awburst_o;
   logic        axi_wvalid_o, axi_wready_i, axi_wlast_o;
   logic [3:0]  axi_wstrb_o;
   logic [31:0] axi_wdata_o;
   logic        axi_bvalid_i, axi_bready_o;
   logic [1:0]  axi_bresp_i;
   logic [3:0]  axi_bid_i;
   logic        axi_arvalid_o, axi_arready_i;
   logic [28:0] axi_araddr_o;
   logic [3:0]  axi_arid_o;
   logic [7:0]  axi_arlen_o;
   logic [1:0]  axi_arburst_o;
   logic        axi_rvalid_i, axi_rready_o, axi_rlast_i;
   logic [1:0]  axi_rresp_i;
   logic [3:0]  axi_rid_i;
   logic [31:0] axi_rdata_i;

   always #5 clock = ~clock;

   axi_ddr3_tester #(.BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
      .clock(clock), .arst_n(arst_n), .start_i(start_i), .seed_i(seed_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
      .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
      .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
      .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o),
      .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
      .axi_wlast_o(axi_wlast_o), .axi_wstrb_o(axi_wstrb_o), .axi_wdata_o(axi_wdata_o),
      .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
      .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
      .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
      .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
      .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
      .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
      .axi_rlast_i(axi_rlast_i), .axi_rresp_i(axi_rresp_i),
      .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int k, input logic [31:0] s);
      logic [15:0] k16;
      k16 = 16'(k);
      return {~k16, k16} ^ s;
   endfunction

   // Configuration written by the main sequence, read by the slave
   logic [31:0] m_seed;
   bit          stall_en;
   int          f_corrupt, f_bad_id, f_early, f_drop, f_bresp, f_rresp;

   // Slave state and observations
   logic [31:0] mem [64];
   logic [31:0] w17;
   int  aw_cnt, ar_cnt, b_cnt, wk, rk, w_beat, r_beat, aw_word, r_base;
   int  proto_err, viol;
   int  aw_stall, w_stall, ar_stall, r_stall;
   bit  b_pend, r_act, r_shown, prev_busy;
   bit  p_awv, p_awhs, p_wv, p_whs, p_wlast, p_arv, p_arhs;
   logic [28:0] p_awaddr, p_araddr;
   logic [31:0] p_wdata;

   function automatic int new_stall();
      return stall_en ? int'($urandom_range(0, 7)) : 0;
   endfunction

   task automatic slave_clear();
      aw_cnt = 0; ar_cnt = 0; b_cnt = 0; wk = 0; rk = 0; w_beat = 0; r_beat = 0;
      aw_word = 0; r_base = 0; proto_err = 0; viol = 0;
      aw_stall = new_stall(); w_stall = new_stall(); ar_stall = new_stall(); r_stall = new_stall();
      b_pend = 0; r_act = 0; r_shown = 0;
      p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_wlast = 0; p_arv = 0; p_arhs = 0;
      p_awaddr = '0; p_araddr = '0; p_wdata = '0;
   endtask

   // Slave: inputs chosen at the falling edge, so each handshake is known in advance
   initial begin : slave
      bit aw_hs, w_hs, b_hs, ar_hs;
      logic [31:0] d;
      axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0; axi_bid_i = 0;
      axi_arready_i = 0; axi_rvalid_i = 0; axi_rlast_i = 0; axi_rresp_i = 0; axi_rid_i = 0;
      axi_rdata_i = 0; w17 = 0; prev_busy = 0;
      slave_clear();
      forever begin
         @(negedge clock);
         if (!arst_n) begin
            axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0;
            axi_arready_i = 0; axi_rvalid_i = 0; axi_rlast_i = 0;
            prev_busy = 0;
            slave_clear();
         end else begin
            if (busy_o && !prev_busy) slave_clear();
            prev_busy = busy_o;
            // valid must stay up with a stable payload until accepted
            if (p_awv && !p_awhs && (!axi_awvalid_o || axi_awaddr_o != p_awaddr)) viol++;
            if (p_wv && !p_whs && (!axi_wvalid_o || axi_wdata_o != p_wdata ||
                                   axi_wlast_o != p_wlast)) viol++;
            if (p_arv && !p_arhs && (!axi_arvalid_o || axi_araddr_o != p_araddr)) viol++;
            // B
            axi_bvalid_i = b_pend;
            axi_bid_i    = 4'h5;
            axi_bresp_i  = (b_cnt == f_bresp) ? 2'b10 : 2'b00;
            b_hs = axi_bvalid_i && axi_bready_o;
            if (b_hs) begin b_pend = 0; b_cnt++; end
            // W
            if (axi_wvalid_o && w_stall > 0) begin axi_wready_i = 0; w_stall--; end
            else axi_wready_i = axi_wvalid_o;
            w_hs = axi_wvalid_o && axi_wready_i;
            if (w_hs) begin
               if (axi_wdata_o != pat(wk, m_seed) || axi_wstrb_o != 4'hF ||
                   axi_wlast_o != (w_beat == BL - 1)) proto_err++;
               mem[(aw_word + w_beat) % 64] = axi_wdata_o;
               if (wk == 17) w17 = axi_wdata_o;
               wk++;
               if (w_beat == BL - 1) begin w_beat = 0; b_pend = 1; end
               else w_beat++;
               w_stall = new_stall();
            end
            // AW
            if (axi_awvalid_o && aw_stall > 0) begin axi_awready_i = 0; aw_stall--; end
            else axi_awready_i = axi_awvalid_o;
            aw_hs = axi_awvalid_o && axi_awready_i;
            if (aw_hs) begin
               if (axi_awaddr_o != 29'(aw_cnt * BL * 4) || axi_awlen_o != 8'(BL - 1) ||
                   axi_awid_o != 4'h5 || axi_awburst_o != 2'b01) proto_err++;
               aw_word = int'(axi_awaddr_o[7:2]);
               aw_cnt++;
               aw_stall = new_stall();
            end
            // R
            if (r_act) begin
               if (!r_shown && r_stall > 0) begin
                  axi_rvalid_i = 0; r_stall--;
               end else begin
                  axi_rvalid_i = 1; r_shown = 1;
                  d = mem[(r_base + r_beat) % 64];
                  if (rk == f_corrupt) d = d ^ 32'h1;
                  axi_rdata_i = d;
                  axi_rid_i   = (rk == f_bad_id) ? 4'hA : 4'h5;
                  axi_rresp_i = (rk / BL == f_rresp) ? 2'b10 : 2'b00;
                  axi_rlast_i = (r_beat == BL - 1);
                  if (rk == f_early) axi_rlast_i = 1;
                  if (rk == f_drop) axi_rlast_i = 0;
                  if (axi_rready_o) begin
                     r_shown = 0; rk++;
                     if (r_beat == BL - 1) begin r_beat = 0; r_act = 0; end
                     else r_beat++;
                     r_stall = new_stall();
                  end
               end
            end else begin
               axi_rvalid_i = 0;
            end
            // AR
            if (axi_arvalid_o && ar_stall > 0) begin axi_arready_i = 0; ar_stall--; end
            else axi_arready_i = axi_arvalid_o;
            ar_hs = axi_arvalid_o && axi_arready_i;
            if (ar_hs) begin
               if (axi_araddr_o != 29'(ar_cnt * BL * 4) || axi_arlen_o != 8'(BL - 1) ||
                   axi_arid_o != 4'h5 || axi_arburst_o != 2'b01) proto_err++;
               r_base = int'(axi_araddr_o[7:2]);
               r_act = 1; r_beat = 0; r_shown = 0;
               ar_cnt++;
               ar_stall = new_stall();
            end
            p_awv = axi_awvalid_o; p_awhs = aw_hs; p_awaddr = axi_awaddr_o;
            p_wv  = axi_wvalid_o;  p_whs  = w_hs;  p_wdata  = axi_wdata_o; p_wlast = axi_wlast_o;
            p_arv = axi_arvalid_o; p_arhs = ar_hs; p_araddr = axi_araddr_o;
         end
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic set_faults(input int ck, input int idk, input int elk, input int dlk,
                             input int bb, input int rb);
      f_corrupt = ck; f_bad_id = idk; f_early = elk; f_drop = dlk; f_bresp = bb; f_rresp = rb;
   endtask

   // Issue an accepted start and check AW appears one cycle later
   task automatic start_pass(input logic [31:0] s);
      m_seed  = s;
      seed_i  = s;
      start_i = 1;
      tick();
      start_i = 0;
      seed_i  = ~s;
      check("start_latency", 32'({busy_o, done_o, axi_awvalid_o}), 32'b101);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done_o && n < 6000) begin tick(); n++; end
      check("done_reached", 32'(done_o), 32'd1);
   endtask

   task automatic check_pass(input string tag, input bit ep, input logic [15:0] ee);
      check({tag, "_pass"},  32'(pass_o), 32'(ep));
      check({tag, "_err"},   32'(err_count_o), 32'(ee));
      check({tag, "_busy"},  32'(busy_o), 32'd0);
      check({tag, "_proto"}, 32'(proto_err), 32'd0);
      check({tag, "_stable"}, 32'(viol), 32'd0);
      check({tag, "_bursts"}, 32'({8'(aw_cnt), 8'(b_cnt), 8'(ar_cnt)}), 32'h040404);
      check({tag, "_rbeats"}, 32'(rk), 32'(NB * BL));
   endtask

   typedef struct {
      logic [31:0] seed;
      bit          stall;
      int          ck, idk, elk, dlk, bb, rb;
      bit          ep;
      logic [15:0] ee;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [31:0] zero_outs();
      return 32'({busy_o, done_o, pass_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o,
                  axi_bready_o, axi_arvalid_o, axi_rready_o});
   endfunction

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : main
      int n;
      vecs[0] = '{32'h0000_0000, 0, -1, -1, -1, -1, -1, -1, 1, 16'd0};
      vecs[1] = '{32'h0000_0000, 0,  5, -1, -1, -1, -1, -1, 0, 16'd1};
      vecs[2] = '{32'h0000_0000, 0, -1, -1, -1, -1,  2,  0, 0, 16'd17};
      vecs[3] = '{32'hA5A5_5A5A, 1, -1, -1, -1, -1, -1, -1, 1, 16'd0};
      vecs[4] = '{32'h1234_5678, 1, 40, 20,  3, -1, -1, -1, 0, 16'd3};
      vecs[5] = '{32'hDEAD_BEEF, 1, 63, 63, -1, 47, -1, -1, 0, 16'd3};

      arst_n = 0; start_i = 0; seed_i = 0; m_seed = 0; stall_en = 0;
      set_faults(-1, -1, -1, -1, -1, -1);
      repeat (3) tick();
      check("reset_flags", zero_outs(), 32'd0);
      check("reset_err", 32'(err_count_o), 32'd0);
      check("reset_addr", 32'(axi_awaddr_o), 32'd0);
      arst_n = 1;
      repeat (2) tick();
      check("idle_flags", zero_outs(), 32'd0);

      for (int i = 0; i < 6; i++) begin
         stall_en = vecs[i].stall;
         set_faults(vecs[i].ck, vecs[i].idk, vecs[i].elk, vecs[i].dlk, vecs[i].bb, vecs[i].rb);
         start_pass(vecs[i].seed);
         wait_done();
         check_pass($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ee);
         if (i == 0) check("wdata_beat17", w17, 32'hFFEE_0011);
         tick();
      end

      // done/pass/err stay put while idle in DONE
      repeat (5) tick();
      check("done_sticky", 32'({done_o, pass_o, err_count_o}), {15'd0, 1'b1, 1'b0, 16'd3});

      // Asynchronous reset in the middle of a write burst
      stall_en = 0;
      set_faults(-1, -1, -1, -1, -1, -1);
      start_pass(32'h0F0F_F0F0);
      n = 0;
      while (wk < 8 && n < 500) begin tick(); n++; end
      check("pre_reset_wvalid", 32'(axi_wvalid_o), 32'd1);
      arst_n = 0;
      #1;
      check("async_reset_flags", zero_outs(), 32'd0);
      check("async_reset_err", 32'(err_count_o), 32'd0);
      repeat (2) tick();
      arst_n = 1;
      tick();
      start_pass(32'h3C3C_C3C3);
      wait_done();
      check_pass("after_reset", 1, 16'd0);

      // start_i during the read phase must be ignored
      stall_en = 1;
      start_pass(32'h5555_AAAA);
      n = 0;
      while (rk < 20 && n < 3000) begin tick(); n++; end
      check("in_read_phase", 32'(busy_o && rk >= 20), 32'd1);
      seed_i  = 32'hFFFF_FFFF;
      start_i = 1;
      tick();
      start_i = 0;
      check("ignored_start", 32'({busy_o, done_o}), 32'b10);
      wait_done();
      check_pass("ignored", 1, 16'd0);

      // Restart from DONE with a new seed
      tick();
      start_pass(32'hC001_D00D);
      wait_done();
      check_pass("restart", 1, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
